// File: rtl/gpc_pkg.sv
// gpc_pkg: shared GPC fetch-controller types and constants
package gpc_pkg;
    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        EXEC,
        HALT
    } gpc_fetch_state_t;
    localparam logic [31:0] GPC_RESET_PC    = 32'h8000_0000;
    localparam logic [31:0] GPC_INST_EBREAK = 32'h0010_0073;
endpackage

// File: rtl/gpc_fetch_ctrl_if.sv
// gpc_fetch_ctrl_if: instruction memory request/response port
interface gpc_fetch_ctrl_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/gpc_fetch_ctrl.sv
// gpc_fetch_ctrl: multi-cycle fetch/execute sequencer owning the GPC program counter
module gpc_fetch_ctrl
    import gpc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = GPC_RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    gpc_fetch_ctrl_if.master         imem,
    output logic [31:0]              inst,
    output logic                     inst_valid,
    input  logic                     exe_done,
    input  logic [31:0]              next_pc,
    input  logic                     ebreak,
    output logic [31:0]              pc,
    output logic                     halted,
    output logic                     fault,
    output logic [31:0]              retired
);
    gpc_fetch_state_t state;

    assign imem.req_valid = state == FETCH_REQ;
    assign imem.req_addr  = pc;
    assign inst_valid     = state == EXEC;
    assign halted         = state == HALT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            inst    <= '0;
            retired <= '0;
            fault   <= 1'b0;
        end else begin
            case (state)
                IDLE:       state <= FETCH_REQ;
                FETCH_REQ:  if (imem.req_ready) state <= FETCH_WAIT;
                FETCH_WAIT: if (imem.rsp_valid) begin
                    inst  <= imem.rsp_data;
                    state <= EXEC;
                end
                EXEC: if (exe_done) begin
                    // ebreak retires even with a bad next_pc; a misaligned target does not retire
                    if (ebreak) begin
                        state   <= HALT;
                        retired <= retired + 32'd1;
                    end else if (next_pc[1:0] != 2'b00) begin
                        state <= HALT;
                        fault <= 1'b1;
                    end else begin
                        pc      <= next_pc;
                        retired <= retired + 32'd1;
                        state   <= FETCH_REQ;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpc_fetch_ctrl.sv
// tb_gpc_fetch_ctrl: directed self-checking bench for gpc_fetch_ctrl
module tb_gpc_fetch_ctrl;
    import gpc_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exe_done;
    logic [31:0] next_pc;
    logic        ebreak;
    logic [31:0] pc;
    logic        halted;
    logic        fault;
    logic [31:0] retired;
    int          checks;
    int          failures;

    gpc_fetch_ctrl_if imem ();

    gpc_fetch_ctrl #(.RESET_PC(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (imem),
        .inst       (inst),
        .inst_valid (inst_valid),
        .exe_done   (exe_done),
        .next_pc    (next_pc),
        .ebreak     (ebreak),
        .pc         (pc),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at the negedge of cycle 0 (IDLE) with rst released and all inputs idle.
    task automatic do_reset();
        rst = 1'b1;
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b0;
        imem.rsp_data = '0;
        exe_done = 1'b0;
        next_pc = '0;
        ebreak = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem.req_valid); end
        checks++; if (pc !== BASE) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, BASE); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
        checks++; if (retired !== 32'h0) begin failures++; $display("FAIL reset_retired got=%h exp=0", retired); end
        checks++; if ({inst_valid, halted, fault} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {inst_valid, halted, fault}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        imem.req_ready = 1'b1;
        imem.rsp_valid = 1'b1;
        imem.rsp_data = 32'h1000;
        exe_done = 1'b1;
        ebreak = 1'b0;
        next_pc = BASE + 32'd4;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            exp_pc = BASE + 32'(4 * ((c - 1) / 3));
            checks++; if (imem.req_valid !== (c % 3 == 1)) begin failures++; $display("FAIL b2b_req_valid cyc=%0d got=%b exp=%b", c, imem.req_valid, c % 3 == 1); end
            checks++; if (inst_valid !== (c % 3 == 0)) begin failures++; $display("FAIL b2b_inst_valid cyc=%0d got=%b exp=%b", c, inst_valid, c % 3 == 0); end
            checks++; if (pc !== exp_pc) begin failures++; $display("FAIL b2b_pc cyc=%0d got=%h exp=%h", c, pc, exp_pc); end
            checks++; if (retired !== 32'((c - 1) / 3)) begin failures++; $display("FAIL b2b_retired cyc=%0d got=%0d exp=%0d", c, retired, (c - 1) / 3); end
            if (c % 3 == 1) begin
                checks++; if (imem.req_addr !== exp_pc) begin failures++; $display("FAIL b2b_addr cyc=%0d got=%h exp=%h", c, imem.req_addr, exp_pc); end
            end
            if (c % 3 == 0) begin
                checks++; if (inst !== 32'h1000 + 32'(c - 1)) begin failures++; $display("FAIL b2b_inst cyc=%0d got=%h exp=%h", c, inst, 32'h1000 + 32'(c - 1)); end
            end
            next_pc = BASE + 32'(4 * ((c - 1) / 3 + 1));
            imem.rsp_data = 32'h1000 + 32'(c);
        end
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b1;
        exe_done = 1'b0;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (imem.req_valid !== 1'b1) begin failures++; $display("FAIL stall_req_valid i=%0d got=%b exp=1", i, imem.req_valid); end
            checks++; if (imem.req_addr !== BASE + 32'h10) begin failures++; $display("FAIL stall_addr i=%0d got=%h exp=%h", i, imem.req_addr, BASE + 32'h10); end
            checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL stall_inst_valid i=%0d got=%b exp=0", i, inst_valid); end
        end
        imem.req_ready = 1'b1;
        imem.rsp_valid = 1'b0;
        @(negedge clk);
        imem.req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if ({imem.req_valid, inst_valid} !== 2'b00) begin failures++; $display("FAIL wait_flags i=%0d got=%b exp=00", i, {imem.req_valid, inst_valid}); end
        end
        @(negedge clk);
        imem.rsp_valid = 1'b1;
        imem.rsp_data = GPC_INST_EBREAK;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rsp_cycle_inst_valid got=%b exp=0", inst_valid); end
        @(negedge clk);
        imem.rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL exec_inst_valid got=%b exp=1", inst_valid); end
        checks++; if (inst !== GPC_INST_EBREAK) begin failures++; $display("FAIL exec_inst got=%h exp=%h", inst, GPC_INST_EBREAK); end
    endtask

    task automatic test_ebreak();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if ({inst_valid, halted} !== 2'b10) begin failures++; $display("FAIL exec_hold i=%0d got=%b exp=10", i, {inst_valid, halted}); end
            checks++; if (inst !== GPC_INST_EBREAK) begin failures++; $display("FAIL exec_hold_inst i=%0d got=%h exp=%h", i, inst, GPC_INST_EBREAK); end
        end
        exe_done = 1'b1;
        ebreak = 1'b1;
        next_pc = 32'h1;
        @(negedge clk);
        checks++; if ({halted, fault} !== 2'b10) begin failures++; $display("FAIL ebreak_halt_fault got=%b exp=10", {halted, fault}); end
        checks++; if (pc !== BASE + 32'h10) begin failures++; $display("FAIL ebreak_pc got=%h exp=%h", pc, BASE + 32'h10); end
        checks++; if (retired !== 32'd5) begin failures++; $display("FAIL ebreak_retired got=%0d exp=5", retired); end
        imem.req_ready = 1'b1;
        imem.rsp_valid = 1'b1;
        ebreak = 1'b0;
        next_pc = BASE + 32'h100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({halted, imem.req_valid, inst_valid} !== 3'b100) begin failures++; $display("FAIL halt_quiet i=%0d got=%b exp=100", i, {halted, imem.req_valid, inst_valid}); end
            checks++; if (pc !== BASE + 32'h10 || retired !== 32'd5) begin failures++; $display("FAIL halt_state i=%0d got=%h/%0d exp=%h/5", i, pc, retired, BASE + 32'h10); end
        end
    endtask

    task automatic test_fault();
        do_reset();
        imem.req_ready = 1'b1;
        imem.rsp_valid = 1'b1;
        imem.rsp_data = 32'h0000_0013;
        exe_done = 1'b1;
        next_pc = 32'h8000_0102;
        repeat (3) @(negedge clk);
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL fault_exec got=%b exp=1", inst_valid); end
        @(negedge clk);
        checks++; if ({halted, fault} !== 2'b11) begin failures++; $display("FAIL fault_flags got=%b exp=11", {halted, fault}); end
        checks++; if (pc !== BASE) begin failures++; $display("FAIL fault_pc got=%h exp=%h", pc, BASE); end
        checks++; if (retired !== 32'd0) begin failures++; $display("FAIL fault_retired got=%0d exp=0", retired); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        force dut.retired = 32'hFFFF_FFFF;
        imem.req_ready = 1'b1;
        imem.rsp_valid = 1'b1;
        imem.rsp_data = 32'h0000_0013;
        exe_done = 1'b1;
        next_pc = BASE + 32'd4;
        @(negedge clk);
        release dut.retired;
        repeat (3) @(negedge clk);
        imem.rsp_valid = 1'b0;
        checks++; if (retired !== 32'h0) begin failures++; $display("FAIL wrap_retired got=%h exp=0", retired); end
        checks++; if (pc !== BASE + 32'd4) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", pc, BASE + 32'd4); end
        @(negedge clk);
        checks++; if ({imem.req_valid, inst_valid} !== 2'b00) begin failures++; $display("FAIL wrap_wait got=%b exp=00", {imem.req_valid, inst_valid}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        imem.rsp_valid = 1'b0;
        checks++; if ({imem.req_valid, inst_valid, halted} !== 3'b000) begin failures++; $display("FAIL midrst_flags got=%b exp=000", {imem.req_valid, inst_valid, halted}); end
        checks++; if (pc !== BASE || retired !== 32'h0) begin failures++; $display("FAIL midrst_regs got=%h/%h exp=%h/0", pc, retired, BASE); end
        @(negedge clk);
        checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== BASE) begin failures++; $display("FAIL refetch got=%b/%h exp=1/%h", imem.req_valid, imem.req_addr, BASE); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_ebreak();
        test_fault();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gpc_fetch_ctrl.md
# gpc_fetch_ctrl

Multi-cycle fetch/execute sequencer for the Gwen Processor Core (GPC). Owns the program counter and issues instruction fetches over a valid/ready memory port. Hands each fetched instruction to the GPC datapath and waits for its completion. Advances the PC or halts on `ebreak` or a misaligned target. It sits between the instruction memory and the GPC datapath and is the only writer of `pc`.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address; equals `pc`.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_rsp_valid`  in  1  fetch data valid.
- `imem_rsp_data`  in  32  fetched instruction word.
- `inst`  out  32  latched instruction presented to the datapath.
- `inst_valid`  out  1  `inst` is valid and being executed.
- `exe_done`  in  1  datapath has finished the current instruction.
- `next_pc`  in  32  PC of the following instruction; sampled with `exe_done`.
- `ebreak`  in  1  current instruction is `ebreak`; sampled with `exe_done`.
- `pc`  out  32  program counter.
- `halted`  out  1  core is stopped; sticky until `rst`.
- `fault`  out  1  halt was caused by a misaligned `next_pc`; sticky.
- `retired`  out  32  retired-instruction count.

## Operation
- States: IDLE, FETCH_REQ, FETCH_WAIT, EXEC, HALT.
- Reset values:
  - state = IDLE, `pc` = RESET_PC, `inst` = 0, `retired` = 0.
  - `imem_req_valid`, `inst_valid`, `halted` and `fault` = 0.
- IDLE: unconditionally moves to FETCH_REQ on the next cycle.
- FETCH_REQ:
  - `imem_req_valid` = 1, `imem_req_addr` = `pc`.
  - On `imem_req_ready` the request is accepted and the state moves to FETCH_WAIT.
  - `imem_rsp_valid` is ignored in this state.
- FETCH_WAIT:
  - On `imem_rsp_valid`, `inst` <= `imem_rsp_data` and the state moves to EXEC.
  - The wait is unbounded; there is no timeout.
- EXEC:
  - `inst_valid` = 1; `inst` and `pc` are held stable.
  - On `exe_done`, priority is:
    1. `ebreak`: go to HALT, `pc` unchanged, `retired` += 1.
    2. `next_pc[1:0]` != 0: go to HALT, `fault` <= 1, `pc` unchanged, `retired` unchanged.
    3. Otherwise: `pc` <= `next_pc`, `retired` += 1, go to FETCH_REQ.
- HALT:
  - `halted` = 1; all requests deasserted.
  - All inputs are ignored; only `rst` exits.
- Output encoding: `imem_req_valid`, `inst_valid` and `halted` are decoded from the state register (Moore). The other outputs come directly from registers.
- `retired` wraps from 32'hFFFF_FFFF to 0 without a flag.
- `ebreak` and `next_pc` are don't-care whenever `exe_done` = 0.
- Reset mid-operation: any state returns to IDLE and any in-flight fetch is abandoned. The memory shares `rst` and must not deliver a response for a request issued before reset.

## Timing
- Reset deasserted at cycle 0: IDLE at cycle 0, first `imem_req_valid` at cycle 1.
- Best-case throughput, with `imem_req_ready` = 1, response on the cycle after acceptance, and `exe_done` in the first EXEC cycle:
  - 3 cycles per instruction (FETCH_REQ, FETCH_WAIT, EXEC).
- The new `pc` is visible in the cycle after `exe_done`, together with the next request.
- `halted` rises in the cycle after the terminating `exe_done`.
- Once `imem_req_valid` is raised, it and the address stay stable until `imem_req_ready`.

## Structure
- Shared package `gpc_pkg` holds:
  - the state enum `gpc_fetch_state_t`;
  - `GPC_RESET_PC` (32'h8000_0000);
  - `GPC_INST_EBREAK` (32'h0010_0073), for datapath and testbench use.
- No sub-module: a single FSM plus PC, instruction and retire registers.

## Test plan
- Reset, then memory always ready with a 1-cycle response, `exe_done` immediate, `next_pc` = `pc`+4, 4 instructions -> `imem_req_addr` sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C at cycles 1, 4, 7, 10; `retired` = 4.
- Hold `imem_req_ready` low for 5 cycles, then return the response after a 3-cycle wait -> request and address held stable throughout; `inst` equals the returned data; `inst_valid` rises the cycle after `imem_rsp_valid`.
- `exe_done` with `ebreak` = 1 and `next_pc` = 0x1 -> HALT; `halted` = 1, `fault` = 0; `pc` unchanged; `retired` +1; no further requests despite stimulus.
- `exe_done` with `next_pc` = 0x8000_0102 -> `fault` = 1, `halted` = 1; `pc` unchanged; `retired` unchanged.
- Preload `retired` = 32'hFFFF_FFFF via force, then retire one instruction -> `retired` = 0; assert `rst` during FETCH_WAIT -> next cycle IDLE, `pc` = 0x8000_0000, then a fresh fetch at 0x8000_0000.
